lsu_mem_stage: RTL

- Load/store unit for the MEM stage of the pipelined RV32I core.
- Accepts one load or store per request from the EX/MEM register and drives a req/gnt/rvalid data-memory port.
- Aligns and sign-extends returned load data, and stalls the pipeline until the access completes.
- load_data feeds the writeback result-select 4:1 mux as its memory-data input.

---
 rtl/core_pkg.sv | 32 +++
 rtl/lsu_mem_stage_if.sv | 23 ++
 rtl/lsu_load_align.sv | 25 ++
 rtl/lsu_mem_stage.sv | 135 +++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I load/store definitions: funct3 codes, LSU state, legality check.
package core_pkg;

   localparam int XLEN = 32;
   localparam int BE_W = XLEN / 8;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE
   } lsu_state_t;

   // True when funct3 is a valid code for the direction and the offset suits its size.
   function automatic logic lsu_ok(input logic we, input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_B:    return 1'b1;
         F3_BU:   return !we;
         F3_H:    return !off[0];
         F3_HU:   return !we && !off[0];
         F3_W:    return off == 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// rtl/lsu_mem_stage_if.sv - req/gnt/rvalid data-memory port between the LSU (master) and memory (slave).
interface lsu_mem_stage_if #(
   parameter int ADDR_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/half of a read word and sign- or zero-extends it.
module lsu_load_align
   import core_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] shifted;

   assign shifted = rdata >> {off, 3'b000};

   always_comb begin
      case (funct3)
         F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   result = {24'b0, shifted[7:0]};
         F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   result = {16'b0, shifted[15:0]};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - MEM-stage load/store unit: one access per request, stalls until it retires.
module lsu_mem_stage
   import core_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   input  logic                 req_we,
   input  logic [2:0]           req_funct3,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [31:0]          req_wdata,
   output logic                 stall,
   output logic                 done,
   output logic [31:0]          load_data,
   output logic                 err_misalign,
   output logic                 err_bus,
   lsu_mem_stage_if.master      mem
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   lsu_state_t        state;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [BE_W-1:0]   be_q;
   logic [2:0]        f3_q;
   logic              we_q;
   logic [CW-1:0]     cnt;
   logic              err_mis_q;
   logic              err_bus_q;
   logic [BE_W-1:0]   be_n;
   logic [31:0]       wdata_n;
   logic [31:0]       aligned;
   logic              expire;

   // funct3[1:0] encodes the access size for both signed and unsigned codes.
   always_comb begin
      be_n    = 4'b1111;
      wdata_n = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            be_n    = 4'b0001 << req_addr[1:0];
            wdata_n = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be_n    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
      if (!req_we) wdata_n = '0;
   end

   lsu_load_align u_align (
      .rdata  (mem.mem_rdata),
      .off    (addr_q[1:0]),
      .funct3 (f3_q),
      .result (aligned)
   );

   assign expire = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         f3_q      <= '0;
         we_q      <= 1'b0;
         cnt       <= '0;
         err_mis_q <= 1'b0;
         err_bus_q <= 1'b0;
         load_data <= '0;
      end else begin
         cnt <= '0;
         case (state)
            ST_IDLE: begin
               err_mis_q <= 1'b0;
               err_bus_q <= 1'b0;
               if (req_valid) begin
                  if (lsu_ok(req_we, req_funct3, req_addr[1:0])) begin
                     state   <= ST_REQ;
                     addr_q  <= req_addr;
                     wdata_q <= wdata_n;
                     be_q    <= be_n;
                     f3_q    <= req_funct3;
                     we_q    <= req_we;
                  end else begin
                     state     <= ST_DONE;
                     err_mis_q <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               if (mem.mem_gnt) begin
                  state <= we_q ? ST_DONE : ST_WAIT;
               end else if (expire) begin
                  state     <= ST_DONE;
                  err_bus_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_WAIT: begin
               if (mem.mem_rvalid) begin
                  load_data <= aligned;
                  state     <= ST_DONE;
               end else if (expire) begin
                  state     <= ST_DONE;
                  err_bus_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign done         = (state == ST_DONE);
   assign err_misalign = done && err_mis_q;
   assign err_bus      = done && err_bus_q;
   assign stall        = (req_valid && state == ST_IDLE) || state == ST_REQ || state == ST_WAIT;

   assign mem.mem_req   = (state == ST_REQ);
   assign mem.mem_we    = mem.mem_req && we_q;
   assign mem.mem_be    = mem.mem_req ? be_q : '0;
   assign mem.mem_addr  = mem.mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign mem.mem_wdata = mem.mem_req ? wdata_q : '0;

endmodule
